// File: rtl/ip_codma_fifo_pkg.sv
// ip_codma_fifo_pkg: shared entry type and default sizes for the CODMA address-phase FIFO.
package ip_codma_fifo_pkg;
  localparam int CODMA_AP_FIFO_DEPTH_DEF = 4;
  localparam int CODMA_ADDR_W = 32;
  localparam int CODMA_SIZE_W = 3;
  typedef struct packed {
    logic read;
    logic write;
    logic [CODMA_ADDR_W-1:0] addr;
    logic [CODMA_SIZE_W-1:0] size;
  } codma_ap_entry_t;
endpackage

// File: rtl/ip_codma_fifo_ptr.sv
// ip_codma_fifo_ptr: wrap counter 0..DEPTH-1 with synchronous clear priority over increment.
module ip_codma_fifo_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [PW-1:0] ptr_o
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_inc;
  assign w_ptr_inc = (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_ptr <= '0;
    else r_ptr <= clr_i ? '0 : inc_i ? w_ptr_inc : r_ptr;
  assign ptr_o = r_ptr;
endmodule

// File: rtl/ip_codma_ap_fifo_v2.sv
// ip_codma_ap_fifo_v2: address-phase FIFO with valid/ready, flush, flags and any depth 1..16.
// Define CODMA_AP_FIFO_ERR_EN to make err_overflow_o, err_illegal_o and hwm_o live.
module ip_codma_ap_fifo_v2
  import ip_codma_fifo_pkg::*;
#(
  parameter int DEPTH = CODMA_AP_FIFO_DEPTH_DEF,
  parameter int ADDR_W = CODMA_ADDR_W,
  parameter int SIZE_W = CODMA_SIZE_W,
  parameter int AFULL_THRESH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic              push_read_i,
  input  logic              push_write_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [SIZE_W-1:0] push_size_i,
  output logic              pop_valid_o,
  input  logic              pop_ready_i,
  output logic              pop_read_o,
  output logic              pop_write_o,
  output logic [ADDR_W-1:0] pop_addr_o,
  output logic [SIZE_W-1:0] pop_size_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              afull_o,
  output logic              err_overflow_o,
  output logic              err_illegal_o,
  output logic [CW-1:0]     hwm_o,
  input  logic              err_clr_i
);
  typedef struct packed {
    logic read;
    logic write;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } entry_t;
  entry_t        r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_wptr;
  logic [PW-1:0] w_rptr;
  logic          w_push;
  logic          w_pop;
  entry_t        w_head;
  assign push_ready_o = r_count < CW'(DEPTH);
  assign pop_valid_o  = r_count != '0;
  // flush suppresses both handshakes so nothing moves in the flush cycle
  assign w_push = push_valid_i && push_ready_o && !flush_i;
  assign w_pop  = pop_valid_o && pop_ready_i && !flush_i;
  assign w_count_next = flush_i ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  ip_codma_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(w_push), .clr_i(flush_i), .ptr_o(w_wptr)
  );
  ip_codma_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk_i(clk_i), .reset_i(reset_i), .inc_i(w_pop), .clr_i(flush_i), .ptr_o(w_rptr)
  );
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) r_count <= '0;
    else r_count <= w_count_next;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (w_push) r_mem[w_wptr] <= '{push_read_i, push_write_i, push_addr_i, push_size_i};
  assign w_head      = r_mem[w_rptr];
  assign pop_read_o  = w_head.read;
  assign pop_write_o = w_head.write;
  assign pop_addr_o  = w_head.addr;
  assign pop_size_o  = w_head.size;
  assign count_o = r_count;
  assign full_o  = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
  assign afull_o = r_count >= CW'(AFULL_THRESH);
`ifdef CODMA_AP_FIFO_ERR_EN
  logic          r_ovf;
  logic          r_ill;
  logic [CW-1:0] r_hwm;
  logic          w_ovf_set;
  logic          w_ill_set;
  assign w_ovf_set = push_valid_i && !push_ready_o;
  assign w_ill_set = w_push && (push_read_i == push_write_i);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      r_ovf <= 1'b0;
      r_ill <= 1'b0;
      r_hwm <= '0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~err_clr_i);
      r_ill <= w_ill_set | (r_ill & ~err_clr_i);
      r_hwm <= err_clr_i ? '0 : (w_count_next > r_hwm) ? w_count_next : r_hwm;
    end
  assign err_overflow_o = r_ovf;
  assign err_illegal_o  = r_ill;
  assign hwm_o          = r_hwm;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr_i;
  assign err_overflow_o = 1'b0;
  assign err_illegal_o  = 1'b0;
  assign hwm_o          = '0;
`endif
endmodule

// File: tb/tb_ip_codma_ap_fifo_v2.sv
// tb_ip_codma_ap_fifo_v2: directed vector table plus corner sequences for the address-phase FIFO.
module tb_ip_codma_ap_fifo_v2;
  import ip_codma_fifo_pkg::*;
`ifdef CODMA_AP_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic flush_i = 0, push_valid_i = 0, push_read_i = 0, push_write_i = 0, pop_ready_i = 0, err_clr_i = 0;
  logic [31:0] push_addr_i = '0;
  logic [2:0] push_size_i = '0;
  logic push_ready_o, pop_valid_o, pop_read_o, pop_write_o, full_o, empty_o, afull_o, err_overflow_o, err_illegal_o;
  logic [31:0] pop_addr_o;
  logic [2:0] pop_size_o, count_o, hwm_o;

  logic b_push_valid = 0, b_pop_ready = 0;
  logic [31:0] b_push_addr = '0;
  logic b_push_ready, b_pop_valid, b_pop_read, b_pop_write, b_full, b_empty, b_afull, b_ovf, b_ill;
  logic [31:0] b_pop_addr;
  logic [2:0] b_pop_size;
  logic [1:0] b_count, b_hwm;

  ip_codma_ap_fifo_v2 #(.DEPTH(4), .ADDR_W(32), .SIZE_W(3), .AFULL_THRESH(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .push_valid_i(push_valid_i),
    .push_ready_o(push_ready_o), .push_read_i(push_read_i), .push_write_i(push_write_i),
    .push_addr_i(push_addr_i), .push_size_i(push_size_i), .pop_valid_o(pop_valid_o),
    .pop_ready_i(pop_ready_i), .pop_read_o(pop_read_o), .pop_write_o(pop_write_o),
    .pop_addr_o(pop_addr_o), .pop_size_o(pop_size_o), .count_o(count_o), .full_o(full_o),
    .empty_o(empty_o), .afull_o(afull_o), .err_overflow_o(err_overflow_o),
    .err_illegal_o(err_illegal_o), .hwm_o(hwm_o), .err_clr_i(err_clr_i)
  );

  ip_codma_ap_fifo_v2 #(.DEPTH(3), .ADDR_W(32), .SIZE_W(3), .AFULL_THRESH(2)) dut3 (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(1'b0), .push_valid_i(b_push_valid),
    .push_ready_o(b_push_ready), .push_read_i(1'b0), .push_write_i(1'b1),
    .push_addr_i(b_push_addr), .push_size_i(3'd2), .pop_valid_o(b_pop_valid),
    .pop_ready_i(b_pop_ready), .pop_read_o(b_pop_read), .pop_write_o(b_pop_write),
    .pop_addr_o(b_pop_addr), .pop_size_o(b_pop_size), .count_o(b_count), .full_o(b_full),
    .empty_o(b_empty), .afull_o(b_afull), .err_overflow_o(b_ovf),
    .err_illegal_o(b_ill), .hwm_o(b_hwm), .err_clr_i(1'b0)
  );

  typedef struct {
    bit pv; bit rd; bit wr; logic [31:0] addr; bit pr; bit fl;
    int e_cnt; bit e_val; logic [31:0] e_addr; bit e_full; bit e_afull; bit e_ovf; bit e_ill; int e_hwm;
  } vec_t;
  vec_t vec [16];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec[0]  = '{1,1,0,32'h10,0,0, 1,1,32'h10,0,0, 0,0,1};
    vec[1]  = '{1,1,0,32'h20,0,0, 2,1,32'h10,0,0, 0,0,2};
    vec[2]  = '{1,1,0,32'h30,0,0, 3,1,32'h10,0,1, 0,0,3};
    vec[3]  = '{1,1,0,32'h40,0,0, 4,1,32'h10,1,1, 0,0,4};
    vec[4]  = '{1,1,0,32'h50,1,0, 3,1,32'h20,0,1, 1,0,4};
    vec[5]  = '{1,1,0,32'h60,1,0, 3,1,32'h30,0,1, 1,0,4};
    vec[6]  = '{0,1,0,32'h00,1,0, 2,1,32'h40,0,0, 1,0,4};
    vec[7]  = '{1,1,0,32'h70,1,0, 2,1,32'h60,0,0, 1,0,4};
    vec[8]  = '{0,1,0,32'h00,1,0, 1,1,32'h70,0,0, 1,0,4};
    vec[9]  = '{0,1,0,32'h00,1,0, 0,0,32'h00,0,0, 1,0,4};
    vec[10] = '{0,1,0,32'h00,1,0, 0,0,32'h00,0,0, 1,0,4};
    vec[11] = '{1,1,0,32'h80,0,0, 1,1,32'h80,0,0, 1,0,4};
    vec[12] = '{1,1,0,32'h90,0,0, 2,1,32'h80,0,0, 1,0,4};
    vec[13] = '{1,1,0,32'hA0,0,0, 3,1,32'h80,0,1, 1,0,4};
    vec[14] = '{1,1,0,32'hB0,1,1, 0,0,32'h00,0,0, 1,0,4};
    vec[15] = '{1,1,1,32'hC0,0,0, 1,1,32'hC0,0,0, 1,1,4};

    #12;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_valid", 32'(pop_valid_o), 0);
    chk("rst_ready", 32'(push_ready_o), 1);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_addr", pop_addr_o, 0);
    reset_i = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      push_valid_i = vec[i].pv; push_read_i = vec[i].rd; push_write_i = vec[i].wr;
      push_addr_i = vec[i].addr; pop_ready_i = vec[i].pr; flush_i = vec[i].fl;
      step();
      chk($sformatf("v%0d_count", i), 32'(count_o), 32'(vec[i].e_cnt));
      chk($sformatf("v%0d_valid", i), 32'(pop_valid_o), 32'(vec[i].e_val));
      chk($sformatf("v%0d_ready", i), 32'(push_ready_o), 32'(vec[i].e_cnt < 4));
      chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'(vec[i].e_cnt == 0));
      chk($sformatf("v%0d_full", i), 32'(full_o), 32'(vec[i].e_full));
      chk($sformatf("v%0d_afull", i), 32'(afull_o), 32'(vec[i].e_afull));
      if (vec[i].e_val) chk($sformatf("v%0d_addr", i), pop_addr_o, vec[i].e_addr);
      chk($sformatf("v%0d_ovf", i), 32'(err_overflow_o), 32'(ERR & vec[i].e_ovf));
      chk($sformatf("v%0d_ill", i), 32'(err_illegal_o), 32'(ERR & vec[i].e_ill));
      chk($sformatf("v%0d_hwm", i), 32'(hwm_o), ERR ? 32'(vec[i].e_hwm) : 0);
    end
    chk("head_rd", 32'(pop_read_o), 1);
    chk("head_wr", 32'(pop_write_o), 1);
    push_valid_i = 0; pop_ready_i = 0; flush_i = 0;

    err_clr_i = 1;
    step();
    err_clr_i = 0;
    chk("clr_ovf", 32'(err_overflow_o), 0);
    chk("clr_ill", 32'(err_illegal_o), 0);
    chk("clr_hwm", 32'(hwm_o), 0);
    chk("clr_count", 32'(count_o), 1);

    b_push_valid = 1; b_push_addr = 0;
    step();
    chk("w3_first", b_pop_addr, 0);
    for (int k = 1; k < 10; k++) begin
      b_push_addr = 32'(k); b_pop_ready = 1;
      step();
      chk($sformatf("w3_addr%0d", k), b_pop_addr, 32'(k));
      chk($sformatf("w3_count%0d", k), 32'(b_count), 1);
    end
    b_push_valid = 0;
    step();
    chk("w3_drain_empty", 32'(b_empty), 1);
    b_pop_ready = 0; b_push_valid = 1;
    for (int k = 0; k < 3; k++) begin
      b_push_addr = 32'(100 + k);
      step();
    end
    b_push_valid = 0;
    chk("w3_full", 32'(b_full), 1);
    chk("w3_ready", 32'(b_push_ready), 0);
    chk("w3_head", b_pop_addr, 100);

    push_valid_i = 1; push_read_i = 0; push_write_i = 1; push_addr_i = 32'hD0;
    step();
    chk("burst_count", 32'(count_o), 2);
    push_addr_i = 32'hE0;
    #3 reset_i = 1'b1;
    #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_valid", 32'(pop_valid_o), 0);
    chk("arst_ready", 32'(push_ready_o), 1);
    chk("arst_hwm", 32'(hwm_o), 0);
    chk("arst_addr", pop_addr_o, 0);
    chk("arst_empty", 32'(empty_o), 1);
    push_valid_i = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    step();
    chk("post_rst_count", 32'(count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
